seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised time-multiplexed seven-segment scan controller for the board's two 4-digit banks. It is the next-generation display driver for all top-level modes and adds a configurable digit count and dwell time. It also adds per-digit decimal points, 8-level PWM brightness, per-digit blinking, and frame-coherent shadow loading with an acknowledge handshake. Mode FSMs drive `codes`/`load`; outputs go straight to board pins.

## Interface
- `DIGITS`, 8: active digits, 1..8; digit i drives `tub_sel[i]`
- `DIV`, 25000: clk cycles per digit slot; multiple of 8, ≥8
- `BLINK_FRAMES`, 125: frames per blink half-period, ≥1

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  display enable; 0 blanks all outputs
- `codes`  in  4*DIGITS  glyph code of digit i at [4i+3:4i]
- `dp`  in  DIGITS  decimal point per digit
- `blink_mask`  in  DIGITS  digit blinks when set
- `bright`  in  3  duty level 0..7
- `load`  in  1  request shadow update
- `load_ack`  out  1  one-cycle pulse: shadow updated
- `seg_74`  out  8  segments, bank digits 4..7, active-high {a,b,c,d,e,f,g,dp}
- `seg_30`  out  8  segments, bank digits 0..3, same encoding
- `tub_sel`  out  8  one-hot digit select, active-high; bits ≥DIGITS always 0

## Operation
- Glyph codes: 0x0–0x9 digits, 0xA A, 0xB P, 0xC C, 0xD `_`, 0xE E, 0xF blank (all segments off).
- `div_cnt` counts 0..DIV-1. `tick` = (`div_cnt`==DIV-1). On tick, `idx` advances modulo DIGITS.
- Frame boundary = tick with `idx`==DIGITS-1.
- Shadow registers (`codes`, `dp`, `blink_mask`) feed the display; live inputs never do.
- `load` sets `pending`. On a frame boundary with `pending | load`, the shadow captures the live inputs that cycle and `pending` clears. `load_ack` pulses the next cycle.
- `load` while pending: absorbed, no second ack. The source holds inputs stable until ack.
- PWM: `phase` = `div_cnt`/(DIV/8). The digit is lit when `phase` ≤ `bright`. So `bright`=7 is full on and `bright`=0 is 1/8 duty. `bright` is sampled live.
- Blink: frame counter wraps at BLINK_FRAMES-1 and toggles `blink_off`. While `blink_off`=1, masked digits are blanked (segments 0, `tub_sel` still asserted).
- Unlit, blanked, or `en`=0: the relevant outputs are 0. Counters, blink, and load servicing keep running while `en`=0.
- Digit i<4 drives `seg_30`; i≥4 drives `seg_74`. The idle bank is forced to 0, never held (no latches).

## Timing
- Reset values: `div_cnt`=0, `idx`=0, `pending`=0, `blink_off`=0, frame counter 0, shadow codes 0xF, `dp`/mask 0.
- Output reset values: `tub_sel`, `seg_74`, `seg_30`, `load_ack` all 0.
- All outputs are registered. They reflect `idx`/`phase` state with 1-cycle latency.
- Load latency: from a `load` pulse to `load_ack` is at most DIGITS*DIV+1 cycles. If `load` coincides with the boundary, the latency is 1 cycle.
- Reset mid-frame or mid-pending: the pending load is discarded and no ack is issued.
- DIGITS=1: every tick is a frame boundary.

## Configuration
- `SEG_BLINK_EN` defined: frame counter, `blink_off`, and mask shadow are present, as described above.
- Undefined: blink logic is omitted, `blink_mask` is ignored, and `blink_off` is constant 0.

## Structure
- Package `seg_pkg`: glyph code localparams (`GLYPH_A`, `GLYPH_BLANK`, ...), 7-bit segment patterns, and the segment bit-order constants.
- Sub-module `seg_glyph_dec`: combinational 4-bit code → 7-bit pattern, one instance on the selected shadow digit.

## Test plan
Bench parameters: DIGITS=4, DIV=8, BLINK_FRAMES=2.
- Reset, then load codes 0x3210, `bright`=7 → `load_ack` at the first boundary. `tub_sel` cycles 0001→0010→0100→1000, with 8 cycles per slot. `seg_30` shows 0,1,2,3 and `seg_74`=0 throughout.
- DIGITS=8, codes 0x0000_00AE → digits ≥4 appear only on `seg_74`. `seg_30`=0 during slots 4..7 (no stale value).
- `bright`=2 → per slot, segments lit for exactly 3 cycles of 8 and 0 for 5.
- Load mid-frame, change `codes` before ack → old glyphs persist until the boundary; the new glyphs appear from the next frame; exactly one ack.
- `SEG_BLINK_EN`, `blink_mask`=0001 → digit 0 is blank for 2 frames and lit for 2 frames; digits 1..3 are unaffected. Without the macro, digit 0 is always lit.
- `en`=0 for 3 frames with a load pending → outputs all 0, `load_ack` still pulses. Assert `rst` mid-slot → all outputs 0 immediately.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph codes, seven-segment patterns and output bit order for the scan controller.
package seg_pkg;

    typedef logic [6:0] seg_pat_t;

    localparam logic [3:0] GLYPH_A          = 4'hA;
    localparam logic [3:0] GLYPH_P          = 4'hB;
    localparam logic [3:0] GLYPH_C          = 4'hC;
    localparam logic [3:0] GLYPH_UNDERSCORE = 4'hD;
    localparam logic [3:0] GLYPH_E          = 4'hE;
    localparam logic [3:0] GLYPH_BLANK      = 4'hF;

    // Output byte bit positions, {a,b,c,d,e,f,g,dp}.
    localparam int SEG_A_POS  = 7;
    localparam int SEG_B_POS  = 6;
    localparam int SEG_C_POS  = 5;
    localparam int SEG_D_POS  = 4;
    localparam int SEG_E_POS  = 3;
    localparam int SEG_F_POS  = 2;
    localparam int SEG_G_POS  = 1;
    localparam int SEG_DP_POS = 0;

    localparam seg_pat_t PAT_0          = 7'h7E;
    localparam seg_pat_t PAT_1          = 7'h30;
    localparam seg_pat_t PAT_2          = 7'h6D;
    localparam seg_pat_t PAT_3          = 7'h79;
    localparam seg_pat_t PAT_4          = 7'h33;
    localparam seg_pat_t PAT_5          = 7'h5B;
    localparam seg_pat_t PAT_6          = 7'h5F;
    localparam seg_pat_t PAT_7          = 7'h70;
    localparam seg_pat_t PAT_8          = 7'h7F;
    localparam seg_pat_t PAT_9          = 7'h7B;
    localparam seg_pat_t PAT_A          = 7'h77;
    localparam seg_pat_t PAT_P          = 7'h67;
    localparam seg_pat_t PAT_C          = 7'h4E;
    localparam seg_pat_t PAT_UNDERSCORE = 7'h08;
    localparam seg_pat_t PAT_E          = 7'h4F;
    localparam seg_pat_t PAT_BLANK      = 7'h00;

    function automatic logic [7:0] seg_byte(input seg_pat_t pat, input logic dp_bit);
        return {pat, dp_bit};
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational glyph decoder: 4-bit code to 7-bit {a..g} segment pattern.
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output seg_pat_t   pattern
);

    // NOTE: every combinational output gets a default before the case so no latch can be inferred.
    always_comb begin
        pattern = PAT_BLANK;
        case (code)
            4'h0:             pattern = PAT_0;
            4'h1:             pattern = PAT_1;
            4'h2:             pattern = PAT_2;
            4'h3:             pattern = PAT_3;
            4'h4:             pattern = PAT_4;
            4'h5:             pattern = PAT_5;
            4'h6:             pattern = PAT_6;
            4'h7:             pattern = PAT_7;
            4'h8:             pattern = PAT_8;
            4'h9:             pattern = PAT_9;
            GLYPH_A:          pattern = PAT_A;
            GLYPH_P:          pattern = PAT_P;
            GLYPH_C:          pattern = PAT_C;
            GLYPH_UNDERSCORE: pattern = PAT_UNDERSCORE;
            GLYPH_E:          pattern = PAT_E;
            default:          pattern = PAT_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scan controller with PWM brightness and frame-coherent shadow load.
// Optional per-digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DIV          = 25000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   codes,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [2:0]            bright,
    input  logic                  load,
    output logic                  load_ack,
    output logic [7:0]            seg_74,
    output logic [7:0]            seg_30,
    output logic [7:0]            tub_sel
);

    localparam int               CNT_W     = $clog2(DIV);
    localparam int               IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] PHASE_LEN = CNT_W'(DIV / 8);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] codes_sh_q, codes_sh_d;
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic                load_ack_q, load_ack_d;
    logic [7:0]          tub_q, tub_d;
    logic [7:0]          seg_30_q, seg_30_d;
    logic [7:0]          seg_74_q, seg_74_d;

    logic                tick, frame_end, capture;
    logic                blink_off, mask_bit;
    logic [3:0]          cur_code;
    logic                cur_dp;
    seg_pat_t            cur_pat;

    always_comb begin
        tick       = (div_cnt_q == DIV_LAST);
        frame_end  = tick && (idx_q == IDX_LAST);
        capture    = frame_end && (pending_q || load);

        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load arriving on the boundary itself is serviced immediately.
        pending_d  = capture ? 1'b0 : (pending_q || load);
        load_ack_d = capture;
        codes_sh_d = capture ? codes : codes_sh_q;
        dp_sh_d    = capture ? dp    : dp_sh_q;
    end

`ifdef SEG_BLINK_EN
    localparam int              FR_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              blink_off_q, blink_off_d;
    logic [DIGITS-1:0] mask_sh_q, mask_sh_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_off_d = blink_off_q;
        mask_sh_d   = capture ? blink_mask : mask_sh_q;
        if (frame_end) begin
            if (frame_cnt_q == FR_LAST) begin
                frame_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        mask_bit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) mask_bit = mask_sh_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            blink_off_q <= 1'b0;
            mask_sh_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_off_q <= blink_off_d;
            mask_sh_q   <= mask_sh_d;
        end
    end

    assign blink_off = blink_off_q;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;

    assign unused_blink_mask = ^blink_mask;
    assign blink_off         = 1'b0;
    assign mask_bit          = 1'b0;
`endif

    always_comb begin
        cur_code = GLYPH_BLANK;
        cur_dp   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = codes_sh_q[4*i +: 4];
                cur_dp   = dp_sh_q[i];
            end
        end
    end

    seg_glyph_dec u_dec (
        .code    (cur_code),
        .pattern (cur_pat)
    );

    always_comb begin
        logic [2:0]       idx_w;
        logic [CNT_W-1:0] phase;
        logic             lit;
        logic [7:0]       cur_seg;

        idx_w   = 3'(idx_q);
        phase   = div_cnt_q / PHASE_LEN;
        lit     = en && (phase <= CNT_W'(bright));
        cur_seg = seg_byte(cur_pat, cur_dp);
        if (blink_off && mask_bit) begin
            cur_seg = '0;
        end

        // The idle bank is driven to zero every cycle rather than holding its last value.
        tub_d    = lit ? (8'b1 << idx_w) : 8'b0;
        seg_30_d = (lit && !idx_w[2]) ? cur_seg : 8'b0;
        seg_74_d = (lit &&  idx_w[2]) ? cur_seg : 8'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            // NOTE: the shadow bank is reset to blank glyphs so nothing shows before the first load.
            codes_sh_q <= {DIGITS{GLYPH_BLANK}};
            dp_sh_q    <= '0;
            load_ack_q <= 1'b0;
            tub_q      <= '0;
            seg_30_q   <= '0;
            seg_74_q   <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            codes_sh_q <= codes_sh_d;
            dp_sh_q    <= dp_sh_d;
            load_ack_q <= load_ack_d;
            tub_q      <= tub_d;
            seg_30_q   <= seg_30_d;
            seg_74_q   <= seg_74_d;
        end
    end

    assign load_ack = load_ack_q;
    assign tub_sel  = tub_q;
    assign seg_30   = seg_30_q;
    assign seg_74   = seg_74_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 4-digit and an 8-digit instance against a time-based reference model.
module tb_seg_scan_mux;

    localparam int DIV = 8;
    localparam int BF  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] codes_in = 32'hFFFF_FFFF;
    logic [7:0]  dp_in = 8'h00;
    logic [7:0]  mask_in = 8'h00;
    logic [2:0]  bright = 3'd7;
    logic        load = 1'b0;

    logic [1:0]      ack_w;
    logic [1:0][7:0] tub_w, s30_w, s74_w;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(4), .DIV(DIV), .BLINK_FRAMES(BF)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .codes(codes_in[15:0]), .dp(dp_in[3:0]),
        .blink_mask(mask_in[3:0]), .bright(bright), .load(load), .load_ack(ack_w[0]),
        .seg_74(s74_w[0]), .seg_30(s30_w[0]), .tub_sel(tub_w[0])
    );

    seg_scan_mux #(.DIGITS(8), .DIV(DIV), .BLINK_FRAMES(BF)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .codes(codes_in), .dp(dp_in),
        .blink_mask(mask_in), .bright(bright), .load(load), .load_ack(ack_w[1]),
        .seg_74(s74_w[1]), .seg_30(s30_w[1]), .tub_sel(tub_w[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nd(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    // ---------------- reference model ----------------
    // Position in the scan is derived from the cycle count since reset.
    logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h67, 7'h4E, 7'h08, 7'h4F, 7'h00};
    int         t;
    logic       pend    [2];
    logic [3:0] sh_code [2][8];
    logic       sh_dp   [2][8];
    logic       sh_mask [2][8];
    logic [7:0] e_tub [2], e_s30 [2], e_s74 [2];
    logic       e_ack [2];

    task automatic model_step(input int k);
        int n, flen, slot, pos;
        logic boff, lit_m;
        logic [7:0] segv;
        n    = nd(k);
        flen = DIV * n;
        slot = (t / DIV) % n;
        pos  = t % DIV;
        boff = 1'b0;
`ifdef SEG_BLINK_EN
        boff = (((t / flen) / BF) % 2) == 1;
`endif
        lit_m = en && ((pos / (DIV / 8)) <= int'(bright));
        segv  = {glyph_tab[sh_code[k][slot]], sh_dp[k][slot]};
        if (boff && sh_mask[k][slot]) segv = 8'h00;
        e_tub[k] = lit_m ? 8'(1 << slot) : 8'h00;
        e_s30[k] = (lit_m && slot < 4) ? segv : 8'h00;
        e_s74[k] = (lit_m && slot >= 4) ? segv : 8'h00;
        e_ack[k] = 1'b0;
        if ((t % flen) == flen - 1 && (pend[k] || load)) begin
            for (int d = 0; d < n; d++) begin
                sh_code[k][d] = codes_in[4*d +: 4];
                sh_dp[k][d]   = dp_in[d];
                sh_mask[k][d] = mask_in[d];
            end
            pend[k]  = 1'b0;
            e_ack[k] = 1'b1;
        end else if (load) begin
            pend[k] = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = 0;
            for (int k = 0; k < 2; k++) begin
                pend[k] = 1'b0;
                e_tub[k] = 8'h00; e_s30[k] = 8'h00; e_s74[k] = 8'h00; e_ack[k] = 1'b0;
                for (int d = 0; d < 8; d++) begin
                    sh_code[k][d] = 4'hF; sh_dp[k][d] = 1'b0; sh_mask[k][d] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
            t++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d tub_sel", nd(k)), 32'(tub_w[k]), 32'(e_tub[k]));
                check($sformatf("dut%0d seg_30", nd(k)), 32'(s30_w[k]), 32'(e_s30[k]));
                check($sformatf("dut%0d seg_74", nd(k)), 32'(s74_w[k]), 32'(e_s74[k]));
                check($sformatf("dut%0d load_ack", nd(k)), 32'(ack_w[k]), 32'(e_ack[k]));
            end
        end
    end

    // ---------------- directed and random stimulus ----------------
    task automatic pulse_load();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic wait_ack(input int k, input int bound);
        int lat;
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (ack_w[k] === 1'b1) begin
                lat = i;
                break;
            end
        end
        check($sformatf("dut%0d ack within bound", nd(k)), 32'(lat >= 0), 32'd1);
    endtask

    task automatic wait_phase(input int modulo, input int target);
        do begin
            @(posedge clk); #1;
        end while ((t % modulo) != target);
    endtask

    initial begin
        logic [7:0] seen [8];
        int         cnt [8];
        logic [7:0] vals [60];
        int         n_a, n_b, n_c, ack_i;

        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("reset tub_sel", 32'(tub_w[k]), 32'h0);
            check("reset seg_30", 32'(s30_w[k]), 32'h0);
            check("reset seg_74", 32'(s74_w[k]), 32'h0);
            check("reset load_ack", 32'(ack_w[k]), 32'h0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Load 0x3210 at full brightness and scan one frame of the 4-digit instance.
        en = 1'b1; bright = 3'd7; codes_in = 32'h0000_3210;
        pulse_load();
        wait_ack(0, 4 * DIV + 2);
        for (int s = 0; s < 8; s++) begin seen[s] = 8'h00; cnt[s] = 0; end
        n_a = 0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                if (tub_w[0] == 8'(1 << s)) begin seen[s] = s30_w[0]; cnt[s]++; end
            end
            if (s74_w[0] != 8'h00) n_a++;
        end
        check("digit0 glyph 0", 32'(seen[0]), 32'hFC);
        check("digit1 glyph 1", 32'(seen[1]), 32'h60);
        check("digit2 glyph 2", 32'(seen[2]), 32'hDA);
        check("digit3 glyph 3", 32'(seen[3]), 32'hF2);
        for (int s = 0; s < 4; s++) check($sformatf("slot%0d cycles", s), 32'(cnt[s]), 32'd8);
        check("dut4 seg_74 idle", 32'(n_a), 32'd0);

        // Load coinciding with the boundary is acknowledged one cycle later.
        wait_phase(4 * DIV, 4 * DIV - 1);
        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        check("boundary load latency", 32'(ack_w[0]), 32'd1);
        repeat (70) @(posedge clk);

        // 8-digit instance: upper digits appear only on seg_74.
        #1 codes_in = 32'h0000_00AE;
        pulse_load();
        wait_ack(1, 8 * DIV + 2);
        for (int s = 0; s < 8; s++) seen[s] = 8'h00;
        n_a = 0;
        for (int i = 0; i < 8 * DIV; i++) begin
            @(negedge clk);
            for (int s = 0; s < 8; s++) begin
                if (tub_w[1] == 8'(1 << s)) seen[s] = (s < 4) ? s30_w[1] : s74_w[1];
            end
            if (tub_w[1][7:4] != 4'h0 && s30_w[1] != 8'h00) n_a++;
            if (tub_w[1][3:0] != 4'h0 && s74_w[1] != 8'h00) n_a++;
        end
        check("dut8 digit0 glyph E", 32'(seen[0]), 32'h9E);
        check("dut8 digit1 glyph A", 32'(seen[1]), 32'hEE);
        check("dut8 digit4 on seg_74", 32'(seen[4]), 32'hFC);
        check("dut8 digit7 on seg_74", 32'(seen[7]), 32'hFC);
        check("dut8 idle bank zero", 32'(n_a), 32'd0);

        // Brightness 2: three lit cycles of every eight.
        @(posedge clk); #1 bright = 3'd2;
        n_a = 0; n_b = 0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            if (tub_w[0] != 8'h00) n_a++;
            if (s30_w[0] != 8'h00) n_b++;
        end
        check("bright2 tub cycles", 32'(n_a), 32'd12);
        check("bright2 seg cycles", 32'(n_b), 32'd12);

        // Mid-frame load, codes changed before ack, second load absorbed.
        @(posedge clk); #1 bright = 3'd7;
        wait_phase(4 * DIV, 10);
        n_a = 0; ack_i = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            load = (i == 0 || i == 6);
            if (i == 0) codes_in = 32'h0000_5555;
            if (i == 5) codes_in = 32'h0000_6789;
            @(negedge clk);
            vals[i] = s30_w[0];
            if (ack_w[0] === 1'b1) begin n_a++; ack_i = i; end
        end
        load = 1'b0;
        check("single ack for absorbed load", 32'(n_a), 32'd1);
        check("old glyph until boundary", 32'(vals[ack_i]), 32'hFC);
        check("new glyph next frame", 32'(vals[(ack_i < 59) ? ack_i + 1 : 59]), 32'hF6);

        // Blink on digit 0 only.
        @(posedge clk); #1 codes_in = 32'h8888_8888; mask_in = 8'h01;
        pulse_load();
        wait_ack(0, 4 * DIV + 2);
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 16 * DIV; i++) begin
            @(negedge clk);
            if (tub_w[0][0] && s30_w[0] != 8'h00) n_a++;
            if (tub_w[0][0]) n_b++;
            if (tub_w[0][1] && s30_w[0] != 8'h00) n_c++;
        end
`ifdef SEG_BLINK_EN
        check("blink digit0 lit cycles", 32'(n_a), 32'd16);
`else
        check("blink digit0 lit cycles", 32'(n_a), 32'd32);
`endif
        check("blink digit0 tub cycles", 32'(n_b), 32'd32);
        check("blink digit1 unaffected", 32'(n_c), 32'd32);

        // Display disabled for three frames while a load is serviced.
        @(posedge clk); #1 en = 1'b0; load = 1'b1; codes_in = 32'h1234_5678;
        @(posedge clk); #1 load = 1'b0;
        n_a = 0; n_b = 0; n_c = 0;
        for (int i = 0; i < 12 * DIV - 1; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if ((tub_w[k] | s30_w[k] | s74_w[k]) != 8'h00) n_a++;
            end
            if (ack_w[0] === 1'b1) n_b++;
            if (ack_w[1] === 1'b1) n_c++;
        end
        check("en=0 outputs dark", 32'(n_a), 32'd0);
        check("en=0 dut4 ack", 32'(n_b), 32'd1);
        check("en=0 dut8 ack", 32'(n_c), 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 900; i++) begin
            @(posedge clk); #1;
            en      = ($urandom % 8) != 0;
            bright  = 3'($urandom);
            load    = ($urandom % 16) == 0;
            dp_in   = 8'($urandom);
            mask_in = 8'($urandom);
            if ($urandom % 24 == 0) codes_in = $urandom;
        end
        load = 1'b0; en = 1'b1; bright = 3'd7;

        // Reset mid-slot with a load pending: outputs clear at once, no ack afterwards.
        wait_phase(8 * DIV, 3);
        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("async reset tub_sel", 32'(tub_w[k]), 32'h0);
            check("async reset seg_30", 32'(s30_w[k]), 32'h0);
            check("async reset seg_74", 32'(s74_w[k]), 32'h0);
            check("async reset load_ack", 32'(ack_w[k]), 32'h0);
        end
        @(posedge clk); #1 rst = 1'b0;
        n_a = 0;
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            if (ack_w[0] === 1'b1 || ack_w[1] === 1'b1) n_a++;
        end
        check("pending discarded by reset", 32'(n_a), 32'd0);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
